bcd_counter_ctrl: RTL and testbench

Run controller for a multi-digit synchronous BCD count chain. It takes start, stop, lap and load commands and sequences them through a small state machine. A prescaler divides the clock down to count ticks, and the controller ripples BCD carries across DIGITS decimal digits. It sits between front-panel/host command logic and the display path, and is the block that owns and sequences the decimal counters.

---
 rtl/bcd_counter_ctrl_if.sv | 27 ++
 rtl/bcd_counter_ctrl.sv | 134 +++++++++++++
 tb/tb_bcd_counter_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_ctrl_if.sv
// rtl/bcd_counter_ctrl_if.sv - command/status bundle for the BCD run controller
interface bcd_counter_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic                stop;
  logic                lap;
  logic                load_valid;
  logic [4*DIGITS-1:0] load_value;
  logic                load_ready;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] display;
  logic                running;
  logic                lap_hold;
  logic                overflow;
  logic                load_err;

  modport master (
    output start, stop, lap, load_valid, load_value,
    input  load_ready, count, display, running, lap_hold, overflow, load_err
  );

  modport slave (
    input  start, stop, lap, load_valid, load_value,
    output load_ready, count, display, running, lap_hold, overflow, load_err
  );
endinterface

// File: rtl/bcd_counter_ctrl.sv
// rtl/bcd_counter_ctrl.sv - run/pause/lap/load sequencer for a DIGITS-wide BCD count chain
module bcd_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic              clock,
  input  logic              clear,
  bcd_counter_ctrl_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_BAD   = 2'b11;

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_count;
  logic [W-1:0]  r_snap;
  logic          r_hold;
  logic          r_overflow;
  logic          r_load_err;

  logic          w_ready;
  logic          w_load_acc;
  logic          w_stop_act;
  logic          w_start_act;
  logic          w_run_adv;
  logic          w_tick;
  logic          w_all_nine;
  logic          w_bad_digit;
  logic [W-1:0]  w_inc;
  logic [W-1:0]  w_load_clean;

  // A pending stop masks start even in IDLE where the stop itself does nothing.
  assign w_ready     = (r_state == S_IDLE) || (r_state == S_PAUSE);
  assign w_load_acc  = bus.load_valid && w_ready;
  assign w_stop_act  = !w_load_acc && bus.stop;
  assign w_start_act = !w_load_acc && !bus.stop && bus.start && w_ready;
  assign w_run_adv   = (r_state == S_RUN) && !bus.stop;
  assign w_tick      = w_run_adv && (r_presc == PRESC_LAST);

  always_comb begin
    logic carry;
    carry      = 1'b1;
    w_all_nine = 1'b1;
    w_inc      = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_count[4*i +: 4] != 4'd9) w_all_nine = 1'b0;
      if (carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_bad_digit  = 1'b0;
    w_load_clean = bus.load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_value[4*i +: 4] > 4'd9) begin
        w_load_clean[4*i +: 4] = 4'd0;
        w_bad_digit            = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_count    <= '0;
      r_snap     <= '0;
      r_hold     <= 1'b0;
      r_overflow <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_load_err <= 1'b0;
      if (w_load_acc) begin
        r_count    <= w_load_clean;
        r_load_err <= w_bad_digit;
      end else if (w_stop_act) begin
        case (r_state)
          S_RUN: begin
            r_state <= S_PAUSE;
            r_hold  <= 1'b0;
          end
          S_PAUSE: begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_presc <= '0;
          end
          default: ;
        endcase
      end else if (w_start_act) begin
        if (r_state == S_IDLE) r_presc <= '0;
        r_state <= S_RUN;
      end else if (w_run_adv) begin
        // Snapshot takes the pre-increment count when lap and tick coincide.
        if (bus.lap) begin
          if (!r_hold) r_snap <= r_count;
          r_hold <= !r_hold;
        end
        if (w_tick) begin
          r_presc    <= '0;
          r_count    <= w_inc;
          r_overflow <= w_all_nine;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
      if (r_state == S_BAD) begin
        r_state <= S_IDLE;
        r_presc <= '0;
      end
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.count      = r_count;
  assign bus.display    = r_hold ? r_snap : r_count;
  assign bus.running    = (r_state == S_RUN);
  assign bus.lap_hold   = r_hold;
  assign bus.overflow   = r_overflow;
  assign bus.load_err   = r_load_err;
endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// tb/tb_bcd_counter_ctrl.sv - directed and random checks of bcd_counter_ctrl against a decimal model
module tb_bcd_counter_ctrl;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 3;
  localparam int MAXV     = 9999;

  logic clock = 1'b0;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  int m_state;
  int m_phase;
  int m_val;
  int m_snap;
  bit m_hold;
  bit m_ovf;
  bit m_err;

  bcd_counter_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int v;
    int mult;
    int d;
    bit bad;
    if (clear) begin
      m_state = 0; m_phase = 0; m_val = 0; m_snap = 0;
      m_hold = 0; m_ovf = 0; m_err = 0;
      return;
    end
    m_ovf = 0;
    m_err = 0;
    if (bus.load_valid && m_state != 1) begin
      v = 0; mult = 1; bad = 0;
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(bus.load_value[4*i +: 4]);
        if (d > 9) bad = 1;
        else v += d * mult;
        mult *= 10;
      end
      m_val = v;
      m_err = bad;
    end else if (bus.stop) begin
      if (m_state == 1) begin
        m_state = 2;
        m_hold  = 0;
      end else if (m_state == 2) begin
        m_state = 0;
        m_val   = 0;
        m_phase = 0;
      end
    end else if (bus.start && m_state != 1) begin
      if (m_state == 0) m_phase = 0;
      m_state = 1;
    end else if (m_state == 1) begin
      if (bus.lap) begin
        if (!m_hold) begin
          m_snap = m_val;
          m_hold = 1;
        end else begin
          m_hold = 0;
        end
      end
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        if (m_val == MAXV) begin
          m_val = 0;
          m_ovf = 1;
        end else begin
          m_val++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"},   32'(bus.count),      32'(to_bcd(m_val)));
    chk({tag, "_display"}, 32'(bus.display),    32'(m_hold ? to_bcd(m_snap) : to_bcd(m_val)));
    chk({tag, "_running"}, 32'(bus.running),    32'(m_state == 1));
    chk({tag, "_ready"},   32'(bus.load_ready), 32'(m_state != 1));
    chk({tag, "_hold"},    32'(bus.lap_hold),   32'(m_hold));
    chk({tag, "_ovf"},     32'(bus.overflow),   32'(m_ovf));
    chk({tag, "_lderr"},   32'(bus.load_err),   32'(m_err));
  endtask

  task automatic drive(input logic c, input logic s, input logic p, input logic l,
                       input logic lv, input logic [15:0] val);
    clear          = c;
    bus.start      = s;
    bus.stop       = p;
    bus.lap        = l;
    bus.load_valid = lv;
    bus.load_value = val;
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 16'h0);
      cyc(tag);
    end
  endtask

  logic [15:0] rv;

  initial begin
    m_state = 0; m_phase = 0; m_val = 0; m_snap = 0;
    m_hold = 0; m_ovf = 0; m_err = 0;
    drive(1, 0, 0, 0, 0, 16'h0);
    @(negedge clock);

    // reset and basic counting
    cyc("reset");
    chk("reset_display_const", 32'(bus.display), 32'h0);
    chk("reset_ready_const", 32'(bus.load_ready), 32'h1);
    drive(0, 1, 0, 0, 0, 16'h0);
    cyc("start");
    idle(3, "run_a");
    chk("count_after_e3", 32'(bus.count), 32'h0001);
    idle(3, "run_b");
    chk("count_after_e6", 32'(bus.count), 32'h0002);
    chk("running_e6", 32'(bus.running), 32'h1);

    // overflow wrap
    drive(1, 0, 0, 0, 0, 16'h0); cyc("clr2");
    drive(0, 0, 0, 0, 1, 16'h9998); cyc("load9998");
    drive(0, 1, 0, 0, 0, 16'h0); cyc("start2");
    idle(3, "wrap_a");
    chk("count_9999", 32'(bus.count), 32'h9999);
    idle(3, "wrap_b");
    chk("count_wrap0", 32'(bus.count), 32'h0000);
    chk("ovf_pulse", 32'(bus.overflow), 32'h1);
    idle(1, "wrap_c");
    chk("ovf_drop", 32'(bus.overflow), 32'h0);

    // pause preserves prescaler phase
    drive(1, 0, 0, 0, 0, 16'h0); cyc("clr3");
    drive(0, 1, 0, 0, 0, 16'h0); cyc("start3");
    idle(16, "to5");
    drive(0, 0, 1, 0, 0, 16'h0); cyc("stop3");
    idle(10, "paused");
    chk("paused_count", 32'(bus.count), 32'h0005);
    drive(0, 1, 0, 0, 0, 16'h0); cyc("resume");
    idle(1, "resume_a");
    chk("resume_hold5", 32'(bus.count), 32'h0005);
    idle(1, "resume_b");
    chk("resume_inc6", 32'(bus.count), 32'h0006);

    // lap freeze
    drive(1, 0, 0, 0, 0, 16'h0); cyc("clr4");
    drive(0, 0, 0, 0, 1, 16'h0012); cyc("load12");
    drive(0, 1, 0, 0, 0, 16'h0); cyc("start4");
    drive(0, 0, 0, 1, 0, 16'h0); cyc("lap1");
    idle(9, "lapped");
    chk("lap_frozen", 32'(bus.display), 32'h0012);
    chk("lap_count15", 32'(bus.count), 32'h0015);
    drive(0, 0, 0, 1, 0, 16'h0); cyc("lap2");
    chk("lap_release", 32'(bus.display), 32'(bus.count));

    // load with bad digit in PAUSE, load blocked in RUN
    drive(0, 0, 1, 0, 0, 16'h0); cyc("stop5");
    drive(0, 0, 0, 0, 1, 16'h12A4); cyc("load12a4");
    chk("load_clean", 32'(bus.count), 32'h1204);
    chk("load_err_pulse", 32'(bus.load_err), 32'h1);
    drive(0, 1, 0, 0, 0, 16'h0); cyc("start5");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 16'h4321);
      cyc("load_in_run");
    end
    drive(0, 0, 1, 0, 1, 16'h4321); cyc("stop_with_load");
    drive(0, 0, 0, 0, 1, 16'h4321); cyc("load_after_stop");
    chk("load_4321", 32'(bus.count), 32'h4321);

    // clear mid-run, start+stop in IDLE
    drive(0, 1, 0, 0, 0, 16'h0); cyc("start6");
    idle(2, "run6");
    drive(1, 1, 1, 1, 1, 16'h5555); cyc("clr_midrun");
    chk("clr_running", 32'(bus.running), 32'h0);
    drive(0, 1, 1, 0, 0, 16'h0); cyc("start_stop_idle");
    chk("startstop_idle", 32'(bus.running), 32'h0);

    // randomized commands
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) rv = 16'(16'h9990 + $urandom_range(9));
      else rv = 16'($urandom);
      drive(($urandom_range(79) == 0), ($urandom_range(5) == 0), ($urandom_range(9) == 0),
            ($urandom_range(7) == 0), ($urandom_range(7) == 0), rv);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
